// File: rtl/ic_pkg.sv
// Shared interconnect types: 64-bit payload, routed flit and butterfly pairing helper.
package ic_pkg;

  typedef logic [63:0] data_t;

  localparam int unsigned MAX_DEST_W = 8;

  typedef struct packed {
    logic [MAX_DEST_W-1:0] dest;
    data_t                 data;
  } flit_t;

  // Line index of switch k's port 0 in a stage routing on bit b: k with a 0 inserted at bit b.
  function automatic int unsigned pair_lo(int unsigned k, int unsigned b);
    return ((k >> b) << (b + 1)) | (k & ((32'd1 << b) - 32'd1));
  endfunction

endpackage

// File: rtl/ic_switch2x2.sv
// Registered 2x2 routing switch: output port chosen by dest[ROUTE_BIT], one-entry output
// registers, single round-robin pointer that resolves same-output contention.
module ic_switch2x2
  import ic_pkg::*;
#(
  parameter int unsigned ROUTE_BIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  flit_t      in0_flit,
  input  flit_t      in1_flit,
  input  logic [1:0] in_valid,
  output logic [1:0] in_ready,
  output flit_t      out0_flit,
  output flit_t      out1_flit,
  output logic [1:0] out_valid,
  input  logic [1:0] out_ready
);

  flit_t      in_flit [2];
  flit_t      flit_q  [2];
  logic [1:0] valid_q;
  logic       rr_q;
  logic [1:0] tgt;
  logic [1:0] free;
  logic       contended;
  logic [1:0] load;
  logic [1:0] sel;

  assign in_flit[0] = in0_flit;
  assign in_flit[1] = in1_flit;
  assign tgt        = {in1_flit.dest[ROUTE_BIT], in0_flit.dest[ROUTE_BIT]};
  assign free       = ~valid_q | out_ready;
  assign contended  = (&in_valid) && (tgt[0] == tgt[1]);

  always_comb begin
    in_ready = '0;
    load     = '0;
    sel      = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      in_ready[i] = free[tgt[i]] && (!contended || (rr_q == 1'(i)));
      if (in_valid[i] && in_ready[i]) begin
        load[tgt[i]] = 1'b1;
        sel[tgt[i]]  = 1'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      flit_q[0] <= '0;
      flit_q[1] <= '0;
      rr_q      <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < 2; j++) begin
        if (free[j]) begin
          valid_q[j] <= load[j];
          if (load[j]) flit_q[j] <= in_flit[sel[j]];
        end
      end
      // Contended and the shared output is free: the granted input transfers this cycle.
      if (contended && free[tgt[0]]) rr_q <= ~rr_q;
    end
  end

  assign out0_flit = flit_q[0];
  assign out1_flit = flit_q[1];
  assign out_valid = valid_q;

endmodule

// File: rtl/ic_butterfly.sv
// NUM_PORTS x NUM_PORTS registered butterfly network of ic_switch2x2 stages.
// Define IC_BUTTERFLY_PERF_EN to add per-sink saturating stall counters (stall_cnt_o).
module ic_butterfly
  import ic_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  data_t                        in_data_i   [NUM_PORTS],
  input  logic [$clog2(NUM_PORTS)-1:0] in_dest_i   [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]         in_valid_i,
  output logic [NUM_PORTS-1:0]         in_ready_o,
  output data_t                        out_data_o  [NUM_PORTS],
  output logic [NUM_PORTS-1:0]         out_valid_o,
  input  logic [NUM_PORTS-1:0]         out_ready_i
`ifdef IC_BUTTERFLY_PERF_EN
  ,
  output logic [31:0]                  stall_cnt_o [NUM_PORTS]
`endif
);

  localparam int unsigned STAGES = $clog2(NUM_PORTS);

  flit_t src_flit [NUM_PORTS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      src_flit[i]                   = '0;
      src_flit[i].dest[STAGES-1:0]  = in_dest_i[i];
      src_flit[i].data              = in_data_i[i];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned B = STAGES - 1 - s;

    flit_t                up_flit [NUM_PORTS];
    logic [NUM_PORTS-1:0] up_valid;
    logic [NUM_PORTS-1:0] up_ready;
    flit_t                dn_flit [NUM_PORTS];
    logic [NUM_PORTS-1:0] dn_valid;
    logic [NUM_PORTS-1:0] dn_ready;

    if (s == 0) begin : g_src
      assign up_flit    = src_flit;
      assign up_valid   = in_valid_i;
      assign in_ready_o = up_ready;
    end else begin : g_link
      assign up_flit  = g_stage[s-1].dn_flit;
      assign up_valid = g_stage[s-1].dn_valid;
    end

    if (s == STAGES - 1) begin : g_sink
      logic unused_dest;
      assign dn_ready    = out_ready_i;
      assign out_valid_o = dn_valid;
      always_comb begin
        unused_dest = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          out_data_o[i] = dn_flit[i].data;
          unused_dest   = unused_dest ^ (^dn_flit[i].dest);
        end
      end
    end else begin : g_fwd
      assign dn_ready = g_stage[s+1].up_ready;
    end

    // Switch k joins the two lines that differ only in bit B; port 0 is the line with bit B clear.
    for (genvar k = 0; k < NUM_PORTS / 2; k++) begin : g_sw
      localparam int unsigned LO = pair_lo(k, B);
      localparam int unsigned HI = LO | (32'd1 << B);

      ic_switch2x2 #(
        .ROUTE_BIT(B)
      ) u_sw (
        .clk      (clk_i),
        .rst      (rst_i),
        .in0_flit (up_flit[LO]),
        .in1_flit (up_flit[HI]),
        .in_valid ({up_valid[HI], up_valid[LO]}),
        .in_ready ({up_ready[HI], up_ready[LO]}),
        .out0_flit(dn_flit[LO]),
        .out1_flit(dn_flit[HI]),
        .out_valid({dn_valid[HI], dn_valid[LO]}),
        .out_ready({dn_ready[HI], dn_ready[LO]})
      );
    end
  end

`ifdef IC_BUTTERFLY_PERF_EN
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (rst_i) begin
        stall_cnt_o[i] <= '0;
      end else if (out_valid_o[i] && !out_ready_i[i] && (stall_cnt_o[i] != '1)) begin
        stall_cnt_o[i] <= stall_cnt_o[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ic_butterfly.sv
// Self-checking bench for ic_butterfly (NUM_PORTS=8): per-(source,dest) FIFO scoreboard
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ic_butterfly;
  import ic_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  data_t        in_data  [N];
  logic [2:0]   in_dest  [N];
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  data_t        out_data [N];
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready;
`ifdef IC_BUTTERFLY_PERF_EN
  logic [31:0]  stall_cnt [N];
`endif

  ic_butterfly #(
    .NUM_PORTS(N)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_data_i  (in_data),
    .in_dest_i  (in_dest),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
`ifdef IC_BUTTERFLY_PERF_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  dest;
    logic [63:0] data;
  } req_t;

  req_t         src_q [N][$];
  logic [63:0]  exp_q [N][N][$];
  logic [N-1:0] src_hs = '0;
  int           tests = 0;
  int           fails = 0;
  int           acc_cnt   [N];
  int           dlv_cnt   [N];
  int           stall_run [N];
  int           max_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A delivery must be the oldest outstanding value of some source bound for that sink.
  task automatic sink_check(input int d, input logic [63:0] v);
    bit found = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (!found && exp_q[s][d].size() != 0 && exp_q[s][d][0] == v) begin
        void'(exp_q[s][d].pop_front());
        found = 1'b1;
      end
    end
    tests++;
    dlv_cnt[d]++;
    if (!found) begin
      fails++;
      $display("FAIL sink%0d_delivery: got %h, expected the head value of a source queue for this sink", d, v);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int s = 0; s < N; s++) begin
      n += src_q[s].size();
      for (int d = 0; d < N; d++) n += exp_q[s][d].size();
    end
    return n;
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int s, input int d, input logic [63:0] v);
    req_t r;
    r.dest = 3'(d);
    r.data = v;
    src_q[s].push_back(r);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (pending() != 0 && n < 400) begin
      cyc(1);
      n++;
    end
    chk({name, "_drained"}, 64'(pending()), 64'd0);
    cyc(2);
  endtask

  // Source drivers: hold each queued flit until the monitor saw it accepted.
  initial begin
    in_valid = '0;
    for (int s = 0; s < N; s++) begin
      in_data[s] = '0;
      in_dest[s] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (src_hs[s] && src_q[s].size() != 0) void'(src_q[s].pop_front());
        if (src_q[s].size() != 0) begin
          in_valid[s] = 1'b1;
          in_dest[s]  = src_q[s][0].dest;
          in_data[s]  = src_q[s][0].data;
        end else begin
          in_valid[s] = 1'b0;
        end
      end
    end
  end

  // Monitor/compare: samples mid-cycle what the next rising edge will transfer.
  initial begin
    for (int s = 0; s < N; s++) begin
      acc_cnt[s]   = 0;
      dlv_cnt[s]   = 0;
      stall_run[s] = 0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int s = 0; s < N; s++)
          for (int d = 0; d < N; d++) exp_q[s][d].delete();
        src_hs = '0;
      end else begin
        for (int d = 0; d < N; d++)
          if (out_valid[d] && out_ready[d]) sink_check(d, out_data[d]);
        for (int s = 0; s < N; s++) begin
          if (in_valid[s] && in_ready[s]) begin
            exp_q[s][in_dest[s]].push_back(in_data[s]);
            acc_cnt[s]++;
            stall_run[s] = 0;
          end else if (in_valid[s]) begin
            stall_run[s]++;
            if (stall_run[s] > max_stall) max_stall = stall_run[s];
          end else begin
            stall_run[s] = 0;
          end
        end
        src_hs = in_valid & in_ready;
      end
    end
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] acc;
    int          cnt;
    int          a0;
    int          d0;

    out_ready = '1;
    rst       = 1'b1;
    cyc(3);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    acc = '0;
    for (int d = 0; d < N; d++) acc = acc | out_data[d];
    chk("rst_out_data", acc, 64'd0);
    rst = 1'b0;
    cyc(1);

    // Single flit, latency 3
    push(3, 5, 64'hDEAD_BEEF);
    cyc(1);
    chk("t1_accept", 64'(in_valid[3] & in_ready[3]), 64'd1);
    cyc(1);
    chk("t1_lat_c1", 64'(out_valid), 64'd0);
    cyc(1);
    chk("t1_lat_c2", 64'(out_valid), 64'd0);
    cyc(1);
    chk("t1_valid", 64'(out_valid), 64'h20);
    chk("t1_data", out_data[5], 64'hDEAD_BEEF);
    cyc(1);
    chk("t1_gone", 64'(out_valid), 64'd0);
    drain("t1");

    // Permutation i -> 7-i, full rate
    for (int k = 0; k < 100; k++)
      for (int s = 0; s < N; s++) push(s, 7 - s, {16'h2000, 8'(s), 8'h00, 32'(k)});
    cyc(3);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (out_valid == 8'hFF) cnt++;
    end
    chk("t2_full_rate_cycles", 64'(cnt), 64'd100);
    drain("t2");

    // Hotspot: everyone -> sink 0
    max_stall = 0;
    d0 = dlv_cnt[0];
    for (int k = 0; k < 20; k++)
      for (int s = 0; s < N; s++) push(s, 0, {16'h3000, 8'(s), 8'h00, 32'(k)});
    cyc(3);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (i == 0) chk("t3_first_src0", out_data[0], 64'h3000_0000_0000_0000);
      if (i == 1) chk("t3_second_src1", out_data[0], 64'h3000_0100_0000_0000);
      if (out_valid[0]) cnt++;
    end
    chk("t3_sink0_rate", 64'(cnt), 64'd100);
    drain("t3");
    chk("t3_total", 64'(dlv_cnt[0] - d0), 64'd160);
    tests++;
    if (max_stall > 8) begin
      fails++;
      $display("FAIL t3_starvation: longest source wait %0d cycles, required at most 8", max_stall);
    end

    // Backpressure on sink 2
    out_ready[2] = 1'b0;
    a0 = acc_cnt[1];
    d0 = dlv_cnt[2];
    for (int k = 0; k < 10; k++) push(1, 2, 64'h4000 + 64'(k));
    cyc(20);
    chk("t4_buffered", 64'(acc_cnt[1] - a0), 64'd3);
    chk("t4_in_ready_low", 64'(in_ready[1]), 64'd0);
    chk("t4_head_valid", 64'(out_valid[2]), 64'd1);
    chk("t4_head_data", out_data[2], 64'h4000);
    out_ready[2] = 1'b1;
    drain("t4");
    chk("t4_delivered", 64'(dlv_cnt[2] - d0), 64'd10);

    // Reset mid-flight; rr pointer of stage-0 switch 0 left at 1 beforehand
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    a0 = 0;
    for (int s = 0; s < N; s++) a0 += acc_cnt[s];
    push(0, 1, 64'h5000);
    push(4, 1, 64'h5004);
    push(1, 3, 64'h5001);
    push(2, 5, 64'h5002);
    push(3, 6, 64'h5003);
    push(5, 2, 64'h5005);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cnt = 0;
    for (int s = 0; s < N; s++) cnt += acc_cnt[s];
    chk("t5_in_flight", 64'(cnt - a0), 64'd6);
    chk("t5_valid_cleared", 64'(out_valid), 64'd0);
    acc = '0;
    for (int d = 0; d < N; d++) acc = acc | out_data[d];
    chk("t5_data_cleared", acc, 64'd0);
    push(0, 7, 64'h5A00);
    push(4, 7, 64'h5A04);
    cyc(2);
    chk("t5_lat_c1", 64'(out_valid), 64'd0);
    cyc(1);
    chk("t5_lat_c2", 64'(out_valid), 64'd0);
    cyc(1);
    chk("t5_fresh_valid", 64'(out_valid), 64'h80);
    chk("t5_rr_src0_first", out_data[7], 64'h5A00);
    cyc(1);
    chk("t5_src4_second", out_data[7], 64'h5A04);
    drain("t5");

    // Sink 4 stalled for 10 cycles with a valid flit
    out_ready[4] = 1'b0;
    push(0, 4, 64'h6000);
    cnt = 0;
    while (!out_valid[4] && cnt < 20) begin
      cyc(1);
      cnt++;
    end
    chk("t6_arrive", 64'(out_valid[4]), 64'd1);
    cyc(10);
`ifdef IC_BUTTERFLY_PERF_EN
    chk("t6_stall_cnt4", 64'(stall_cnt[4]), 64'd10);
    chk("t6_stall_cnt5", 64'(stall_cnt[5]), 64'd0);
`endif
    chk("t6_held_data", out_data[4], 64'h6000);
    out_ready[4] = 1'b1;
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
